// File: rtl/mem_stage_lsu_if.sv
// mem_stage_lsu_if
//   Wait-state data-memory bus between the memory-stage LSU and data memory.
//   master: LSU side (drives the request, samples ready/rdata).
//   slave : memory side.
//   Signals:
//     mem_req    request outstanding (held until the cycle mem_ready is seen)
//     mem_we     1 = write
//     mem_addr   word-aligned byte address
//     mem_be     byte enables
//     mem_wdata  lane-replicated store data
//     mem_ready  memory completes the request this cycle
//     mem_rdata  read word, valid with mem_ready
interface mem_stage_lsu_if #(
  parameter int DATA_WIDTH = 32
);
  logic                    mem_req;
  logic                    mem_we;
  logic [31:0]             mem_addr;
  logic [DATA_WIDTH/8-1:0] mem_be;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic                    mem_ready;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport master (
    output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    input  mem_ready, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/mem_stage_lsu.sv
// mem_stage_lsu
//   Memory-stage load/store unit. Takes the EX/MEM register outputs, runs one
//   access at a time over a wait-state memory bus (IDLE -> BUSY -> DONE) and
//   returns sign/zero-extended load data for the MEM/WB register. StallM
//   freezes the F/D/E/M registers while an access is outstanding.
//   Optional feature: define MEM_TIMEOUT_EN to abort a BUSY access after
//   TIMEOUT_CYCLES cycles without mem_ready (BusErrM pulses for the DONE cycle).
//   Ports:
//     clk, rst_n              clock (rising edge), asynchronous active-low reset
//     RegWriteM, ResultSrcM   load detection (ResultSrcM == 2'b01 selects memory result)
//     MemWriteM               store
//     ALUResultM              byte address
//     WriteDataM              store data
//     modeAddrM               funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU, others = W
//     ReadDataM               extended load data, valid while StallM = 0
//     StallM                  pipeline freeze request
//     MisalignM               misaligned access (combinational)
//     BusErrM                 access aborted by timeout
//     bus                     memory bus (mem_stage_lsu_if.master)
module mem_stage_lsu #(
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  RegWriteM,
  input  logic [1:0]            ResultSrcM,
  input  logic                  MemWriteM,
  input  logic [31:0]           ALUResultM,
  input  logic [DATA_WIDTH-1:0] WriteDataM,
  input  logic [2:0]            modeAddrM,
  output logic [DATA_WIDTH-1:0] ReadDataM,
  output logic                  StallM,
  output logic                  MisalignM,
  output logic                  BusErrM,
  mem_stage_lsu_if.master       bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_reg;
  logic [1:0]  lane_reg;   // address low bits of the access in flight
  logic [2:0]  mode_reg;   // funct3 of the access in flight
  logic [31:0] rdata_reg;
  logic        bus_err_reg;
`ifdef MEM_TIMEOUT_EN
  logic [4:0]  cnt_reg;
`endif

  logic        acc;
  logic        is_b;
  logic        is_h;
  logic        misalign;
  logic        start;
  logic [3:0]  be_next;
  logic [31:0] wdata_next;

  // Undefined funct3 codes (011/110/111) fall through to word size.
  assign acc      = MemWriteM | (RegWriteM & (ResultSrcM == 2'b01));
  assign is_b     = (modeAddrM[1:0] == 2'b00);
  assign is_h     = (modeAddrM[1:0] == 2'b01);
  assign misalign = acc & ((is_h & ALUResultM[0]) |
                           (!is_b && !is_h && (ALUResultM[1:0] != 2'b00)));

  // StallM is raised in the same cycle the access appears so the pipeline
  // holds the instruction; gating with rst_n keeps it low throughout reset.
  assign start     = rst_n & (state_reg == IDLE) & acc & !misalign;
  assign StallM    = start | (state_reg == BUSY);
  assign MisalignM = rst_n & misalign;
  assign ReadDataM = misalign ? '0 : rdata_reg;
  assign BusErrM   = bus_err_reg;

  always_comb begin
    be_next    = 4'b1111;
    wdata_next = WriteDataM;
    if (is_b) begin
      be_next    = 4'b0001 << ALUResultM[1:0];
      wdata_next = {4{WriteDataM[7:0]}};
    end else if (is_h) begin
      be_next    = 4'b0011 << {ALUResultM[1], 1'b0};
      wdata_next = {2{WriteDataM[15:0]}};
    end
  end

  function automatic logic [31:0] extend(input logic [31:0] word,
                                         input logic [1:0]  lane,
                                         input logic [2:0]  mode);
    logic [7:0]  b;
    logic [15:0] h;
    b = 8'(word >> {lane, 3'b000});
    h = lane[1] ? word[31:16] : word[15:0];
    case (mode)
      3'b000:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'h0, b};
      3'b001:  extend = {{16{h[15]}}, h};
      3'b101:  extend = {16'h0, h};
      default: extend = word;
    endcase
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      lane_reg      <= 2'b00;
      mode_reg      <= 3'b000;
      rdata_reg     <= '0;
      bus_err_reg   <= 1'b0;
      bus.mem_req   <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_be    <= '0;
      bus.mem_wdata <= '0;
`ifdef MEM_TIMEOUT_EN
      cnt_reg       <= '0;
`endif
    end else begin
      case (state_reg)
        IDLE: begin
          bus_err_reg <= 1'b0;
          if (acc && !misalign) begin
            bus.mem_req   <= 1'b1;
            bus.mem_we    <= MemWriteM;
            bus.mem_addr  <= {ALUResultM[31:2], 2'b00};
            bus.mem_be    <= be_next;
            bus.mem_wdata <= wdata_next;
            lane_reg      <= ALUResultM[1:0];
            mode_reg      <= modeAddrM;
            state_reg     <= BUSY;
`ifdef MEM_TIMEOUT_EN
            cnt_reg       <= '0;
`endif
          end
        end
        BUSY: begin
          // All mem_* outputs hold here; only ready (or the timeout) moves on.
          if (bus.mem_ready) begin
            bus.mem_req <= 1'b0;
            rdata_reg   <= bus.mem_we ? 32'h0 : extend(bus.mem_rdata, lane_reg, mode_reg);
            state_reg   <= DONE;
          end
`ifdef MEM_TIMEOUT_EN
          // The count equals the number of BUSY cycles already elapsed, so
          // this fires on the last permitted BUSY cycle.
          else if (cnt_reg == 5'(TIMEOUT_CYCLES - 1)) begin
            bus.mem_req <= 1'b0;
            rdata_reg   <= 32'h0;
            bus_err_reg <= 1'b1;
            state_reg   <= DONE;
          end else begin
            cnt_reg <= cnt_reg + 5'd1;
          end
`endif
        end
        DONE: begin
          bus_err_reg <= 1'b0;
          state_reg   <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
module tb_mem_stage_lsu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        RegWriteM;
  logic [1:0]  ResultSrcM;
  logic        MemWriteM;
  logic [31:0] ALUResultM;
  logic [31:0] WriteDataM;
  logic [2:0]  modeAddrM;
  logic [31:0] ReadDataM;
  logic        StallM;
  logic        MisalignM;
  logic        BusErrM;

  always #5 clk = ~clk;

  mem_stage_lsu_if bus ();

  mem_stage_lsu dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .modeAddrM  (modeAddrM),
    .ReadDataM  (ReadDataM),
    .StallM     (StallM),
    .MisalignM  (MisalignM),
    .BusErrM    (BusErrM),
    .bus        (bus)
  );

  // kind: 0 = memory access, 1 = misaligned access, 2 = not a memory access
  typedef struct {
    string       name;
    int          kind;
    logic        mw;
    logic        rw;
    logic [1:0]  rs;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  mode;
    logic [31:0] rdata;
    int          waits;
    logic [31:0] exp_rd;
    logic        exp_we;
    logic [3:0]  exp_be;
    logic [31:0] exp_wd;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rd;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input string name, input int kind, input logic mw, input logic rw,
                     input logic [1:0] rs, input logic [31:0] addr, input logic [31:0] wd,
                     input logic [2:0] mode, input logic [31:0] rdata, input int waits,
                     input logic [31:0] exp_rd, input logic exp_we, input logic [3:0] exp_be,
                     input logic [31:0] exp_wd);
    vec_t v;
    v.name = name; v.kind = kind; v.mw = mw; v.rw = rw; v.rs = rs; v.addr = addr;
    v.wd = wd; v.mode = mode; v.rdata = rdata; v.waits = waits; v.exp_rd = exp_rd;
    v.exp_we = exp_we; v.exp_be = exp_be; v.exp_wd = exp_wd;
    vecs.push_back(v);
  endtask

  task automatic idle_inputs();
    MemWriteM = 1'b0; RegWriteM = 1'b0; ResultSrcM = 2'b00;
    ALUResultM = 32'h0; WriteDataM = 32'h0; modeAddrM = 3'b010;
  endtask

  // Called at a negedge with the DUT in IDLE; returns at a negedge in IDLE.
  task automatic run_vec(input vec_t v);
    int          stall_cnt;
    logic        req_seen;
    logic [31:0] exp;
    MemWriteM = v.mw; RegWriteM = v.rw; ResultSrcM = v.rs;
    ALUResultM = v.addr; WriteDataM = v.wd; modeAddrM = v.mode;
    bus.mem_ready = 1'b1;              // must be ignored in IDLE
    bus.mem_rdata = 32'hBAD0BAD0;
    #1;
    if (v.kind != 0) begin
      chk({v.name, " misalign"}, {31'h0, MisalignM}, {31'h0, v.kind == 1});
      chk({v.name, " stall"}, {31'h0, StallM}, 32'h0);
      chk({v.name, " rdata"}, ReadDataM, (v.kind == 1) ? 32'h0 : last_rd);
      req_seen = 1'b0;
      for (int i = 0; i < 3; i++) begin
        @(negedge clk);
        req_seen = req_seen | bus.mem_req | StallM;
      end
      chk({v.name, " no_req"}, {31'h0, req_seen}, 32'h0);
      bus.mem_ready = 1'b0;
      idle_inputs();
      $display("txn %s: kind=%0d misalign=%b rdata=%h", v.name, v.kind, MisalignM, ReadDataM);
      return;
    end
    exp_q.push_back(v.exp_rd);
    chk({v.name, " stall_idle"}, {31'h0, StallM}, 32'h1);
    chk({v.name, " misalign"}, {31'h0, MisalignM}, 32'h0);
    chk({v.name, " req_idle"}, {31'h0, bus.mem_req}, 32'h0);
    stall_cnt = 1;
    for (int w = 0; w <= v.waits; w++) begin
      @(negedge clk);
      bus.mem_ready = (w == v.waits);
      bus.mem_rdata = (w == v.waits) ? v.rdata : ~v.rdata;
      #1;
      if (StallM) stall_cnt++;
      chk({v.name, " req"}, {31'h0, bus.mem_req}, 32'h1);
      chk({v.name, " we"}, {31'h0, bus.mem_we}, {31'h0, v.exp_we});
      chk({v.name, " addr"}, bus.mem_addr, {v.addr[31:2], 2'b00});
      chk({v.name, " be"}, {28'h0, bus.mem_be}, {28'h0, v.exp_be});
      chk({v.name, " wdata"}, bus.mem_wdata, v.exp_wd);
    end
    @(negedge clk);                    // DONE
    bus.mem_ready = 1'b1;              // must be ignored in DONE
    bus.mem_rdata = 32'hBAD0BAD0;
    exp = exp_q.pop_front();
    #1;
    chk({v.name, " stall_done"}, {31'h0, StallM}, 32'h0);
    chk({v.name, " req_done"}, {31'h0, bus.mem_req}, 32'h0);
    chk({v.name, " stall_cycles"}, stall_cnt, 2 + v.waits);
    chk({v.name, " rdata"}, ReadDataM, exp);
    chk({v.name, " buserr"}, {31'h0, BusErrM}, 32'h0);
    last_rd = exp;
    idle_inputs();
    @(negedge clk);                    // IDLE
    chk({v.name, " rdata_hold"}, ReadDataM, last_rd);
    chk({v.name, " stall_after"}, {31'h0, StallM}, 32'h0);
    bus.mem_ready = 1'b0;
    $display("txn %s: addr=%h be=%h we=%b wdata=%h rdata=%h stall=%0d",
             v.name, v.addr, v.exp_be, v.exp_we, v.exp_wd, ReadDataM, stall_cnt);
  endtask

  initial begin
    vec_t v;
    int   busy;
    //   name      kind mw rw rs     addr          wd            mode    rdata        w  exp_rd        we be       exp_wd
    add("LW",       0, 0, 1, 2'b01, 32'h00000100, 32'h00000000, 3'b010, 32'hDEADBEEF, 0, 32'hDEADBEEF, 0, 4'b1111, 32'h00000000);
    add("LB",       0, 0, 1, 2'b01, 32'h00000103, 32'h00000000, 3'b000, 32'h80FF1234, 0, 32'hFFFFFF80, 0, 4'b1000, 32'h00000000);
    add("LBU",      0, 0, 1, 2'b01, 32'h00000103, 32'h00000000, 3'b100, 32'h80FF1234, 0, 32'h00000080, 0, 4'b1000, 32'h00000000);
    add("SH",       0, 1, 0, 2'b00, 32'h00000202, 32'h0000ABCD, 3'b001, 32'h11111111, 3, 32'h00000000, 1, 4'b1100, 32'hABCDABCD);
    add("LH",       0, 0, 1, 2'b01, 32'h00000102, 32'h00000000, 3'b001, 32'h80FF1234, 1, 32'hFFFF80FF, 0, 4'b1100, 32'h00000000);
    add("LHU",      0, 0, 1, 2'b01, 32'h00000100, 32'h00000000, 3'b101, 32'h80FF9234, 0, 32'h00009234, 0, 4'b0011, 32'h00000000);
    add("LB_pos",   0, 0, 1, 2'b01, 32'h00000101, 32'h00000000, 3'b000, 32'h12347F56, 1, 32'h0000007F, 0, 4'b0010, 32'h00000000);
    add("SB",       0, 1, 0, 2'b00, 32'h00000301, 32'h123456A5, 3'b000, 32'h22222222, 0, 32'h00000000, 1, 4'b0010, 32'hA5A5A5A5);
    add("LW_undef", 0, 0, 1, 2'b01, 32'h00000108, 32'h00000000, 3'b011, 32'h01234567, 0, 32'h01234567, 0, 4'b1111, 32'h00000000);
    add("SW",       0, 1, 0, 2'b00, 32'h00000404, 32'hCAFEF00D, 3'b010, 32'h33333333, 2, 32'h00000000, 1, 4'b1111, 32'hCAFEF00D);
    add("LBU_l0",   0, 0, 1, 2'b01, 32'h00000500, 32'h00000000, 3'b100, 32'h000000F3, 0, 32'h000000F3, 0, 4'b0001, 32'h00000000);
    add("LW_mis",   1, 0, 1, 2'b01, 32'h00000101, 32'h00000000, 3'b010, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0);
    add("LH_mis",   1, 0, 1, 2'b01, 32'h00000103, 32'h00000000, 3'b001, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0);
    add("ALU_odd",  2, 0, 1, 2'b00, 32'h00000103, 32'h00000000, 3'b010, 32'h0,        0, 32'h0,        0, 4'b0000, 32'h0);

    idle_inputs();
    bus.mem_ready = 1'b0;
    bus.mem_rdata = 32'h0;
    last_rd = 32'h0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rdata", ReadDataM, 32'h0);
    chk("rst_stall", {31'h0, StallM}, 32'h0);
    chk("rst_req", {31'h0, bus.mem_req}, 32'h0);
    chk("rst_buserr", {31'h0, BusErrM}, 32'h0);
    chk("rst_be", {28'h0, bus.mem_be}, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset asserted while BUSY: request and stall drop immediately.
    v = vecs[0];
    MemWriteM = v.mw; RegWriteM = v.rw; ResultSrcM = v.rs;
    ALUResultM = v.addr; WriteDataM = v.wd; modeAddrM = v.mode;
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    chk("midrst_req_before", {31'h0, bus.mem_req}, 32'h1);
    rst_n = 1'b0;
    #1;
    chk("midrst_req", {31'h0, bus.mem_req}, 32'h0);
    chk("midrst_stall", {31'h0, StallM}, 32'h0);
    chk("midrst_rdata", ReadDataM, 32'h0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("postrst_stall", {31'h0, StallM}, 32'h0);
    chk("postrst_req", {31'h0, bus.mem_req}, 32'h0);
    $display("txn midrst: req=%b stall=%b", bus.mem_req, StallM);
    last_rd = 32'h0;
    run_vec(vecs[0]);

`ifdef MEM_TIMEOUT_EN
    // mem_ready never arrives: abort after 16 BUSY cycles.
    MemWriteM = 1'b0; RegWriteM = 1'b1; ResultSrcM = 2'b01;
    ALUResultM = 32'h00000100; modeAddrM = 3'b010;
    bus.mem_ready = 1'b0;
    busy = 0;
    @(negedge clk);
    for (int n = 0; n < 40; n++) begin
      #1;
      if (!StallM) break;
      busy++;
      @(negedge clk);
    end
    chk("to_busy_cycles", busy, 16);
    chk("to_buserr", {31'h0, BusErrM}, 32'h1);
    chk("to_rdata", ReadDataM, 32'h0);
    chk("to_req", {31'h0, bus.mem_req}, 32'h0);
    idle_inputs();
    @(negedge clk);
    chk("to_buserr_pulse", {31'h0, BusErrM}, 32'h0);
    $display("txn timeout: busy_cycles=%0d", busy);
`else
    // Without the timeout a long wait simply completes normally.
    busy = 0;
    v = vecs[0];
    v.name = "LW_long"; v.waits = 20; v.rdata = 32'h5A5AA5A5; v.exp_rd = 32'h5A5AA5A5;
    run_vec(v);
    chk("long_buserr", {31'h0, BusErrM}, {31'h0, busy != 0});
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
